mem_access_ctrl: RTL
====================

Name: mem_access_ctrl

Overview:
- Initiator-side controller for the word-addressed DataMemory (Address, WriteData, MemWrite, MemRead, ReadData).
- Sits between the MEM pipeline stage and DataMemory.
- Turns byte-addressed lb/lbu/lh/lhu/lw/sb/sh/sw requests into word accesses: lane extraction and sign extension on loads, read-modify-write for sub-word stores.
- Flags misaligned accesses without touching memory.

Parameters:
- ADDR_W, 10, word-index width; DataMemory depth = 2**ADDR_W words (1024).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  request strobe; accepted when ReqValid & ReqReady.
- ReqReady  out  1  high only in IDLE.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqSize  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- ReqSigned  in  1  sign-extend loads (lb/lh); ignored for stores and words.
- ReqAddr  in  32  byte address.
- ReqWData  in  32  store data, right-justified.
- RspValid  out  1  one-cycle completion pulse.
- RspRData  out  32  load result; held until next RspValid.
- AlignErr  out  1  valid with RspValid; misaligned request.
- MemAddress  out  32  word index = {0, ReqAddr[ADDR_W+1:2]}.
- MemWriteData  out  32  word written to DataMemory.
- MemWrite  out  1  write enable; memory writes on rising Clk.
- MemRead  out  1  read enable.
- MemReadData  in  32  DataMemory ReadData; combinational on MemAddress while MemRead=1.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except ReqReady=1. Request latches cleared.
- Endianness is little-endian.
  - Byte lane = ReqAddr[1:0], bits [8*lane+7:8*lane].
  - Half lane = ReqAddr[1], bits [16*h+15:16*h].
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Address bits above ADDR_W+1 are ignored; index wraps modulo 2**ADDR_W.
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, DONE.
- IDLE:
  - ReqReady=1.
  - On accept, latch request.
  - Misaligned → DONE with AlignErr pending.
  - Load → LOAD. Word store → STORE. Byte/half store → RMW_RD.
- LOAD: MemRead=1. At clock edge, capture extracted/extended lane into RspRData → DONE.
- STORE: MemWrite=1, MemWriteData=ReqWData → DONE.
- RMW_RD: MemRead=1. Capture MemReadData into merge register → RMW_WR.
- RMW_WR: MemWrite=1. MemWriteData = captured word with the addressed lane replaced by ReqWData[7:0] or [15:0] → DONE.
- DONE:
  - RspValid=1, ReqReady=0.
  - AlignErr=1 only for misaligned requests; RspRData=0 for misaligned.
  - Stores leave RspRData unchanged.
  - → IDLE.
- Latency, accept edge to RspValid cycle: load/sw 2 cycles, sb/sh 3 cycles, misaligned 1 cycle.
- Throughput: one request per latency+1 cycles; a new accept is possible the cycle after DONE.
- MemRead and MemWrite are never high together. Both are 0 in IDLE and DONE.
- MemAddress holds the latched index from accept until IDLE, then 0.
- ReqValid outside IDLE is ignored; no queuing.
- Reset during RMW_RD or RMW_WR aborts: MemWrite drops asynchronously before the edge, so the memory word retains its pre-request value.
- Zero extension when ReqSigned=0; sign bit = bit 7 or bit 15 of the lane.

Optional Feature:
- Macro MEM_ACCESS_CNT_EN.
- Defined: adds outputs LoadCount[31:0] and StoreCount[31:0].
  - Each increments on a DONE for a successful (aligned) load or store respectively.
  - Each wraps at 2**32; reset to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared header mem_access_defs.vh holds:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD.
  - State encodings.
  - Lane-width constants.
- Sub-module mem_lane_align (combinational): given word, ReqAddr[1:0], size, signed, store data → extracted load value and merged store word.
- The top module owns the FSM, latches and counters.

Test Plan:
- Reset mid-RMW:
  - Stimulus: preload word 5 = 0xAABBCCDD; sb 0x11 to byte addr 20; assert Reset during RMW_WR.
  - Required: MemWrite falls immediately; word 5 stays 0xAABBCCDD; ReqReady=1.
- Word store then load at index 1023:
  - Stimulus: sw 42 @ byte 4092, then lw @ 4092.
  - Required: MemWrite pulse with MemAddress=1023; RspRData=42 two cycles after accept.
- Sub-word stores and signed loads:
  - Stimulus: preload word 0 = 0x80FF7F01; lb @1, lbu @1, lh @2, lhu @2, lb @0.
  - Required: RspRData = 0x0000007F, 0x0000007F, 0xFFFF80FF, 0x000080FF, 0x00000001.
  - Stimulus: sb 0xEE @3, then lw @0.
  - Required: 0xEEFF7F01, with the RMW taking 3 cycles.
  - Stimulus: sh 0x1234 @0, then lw @0.
  - Required: 0xEEFF1234.
- Misaligned:
  - Stimulus: lw @2, sh @1.
  - Required: RspValid one cycle after accept; AlignErr=1; RspRData=0; MemRead/MemWrite never asserted.
- Back-to-back and wrap:
  - Stimulus: ReqValid held high with lw @4096 and @0.
  - Required: both map to MemAddress=0; second accept the cycle after the first DONE; ReqValid ignored while busy.
- MEM_ACCESS_CNT_EN:
  - Stimulus: 3 loads, 2 stores, 1 misaligned.
  - Required: LoadCount=3, StoreCount=2.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the DataMemory access controller: request size
// encodings, FSM state encoding, lane widths/masks and the alignment rule.
package mem_access_ctrl_pkg;

  // Request size encodings; 2'b11 is handled as a word.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Lane geometry for a 32-bit little-endian word.
  localparam int          BYTE_W    = 8;
  localparam int          HALF_W    = 16;
  localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
  localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STORE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // A half must sit on an even byte, a word on a multiple of four.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = addrLo[0];
      default:   mis = |addrLo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus DataMemory bus of the access controller.
// slave  : the controller itself.
// master : its environment (MEM stage driving requests, DataMemory
//          returning ReadData).
interface mem_access_ctrl_if;

  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [1:0]  ReqSize;
  logic        ReqSigned;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspValid;
  logic [31:0] RspRData;
  logic        AlignErr;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemReadData;

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
    input  ReqReady, RspValid, RspRData, AlignErr, MemAddress, MemWriteData, MemWrite, MemRead
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, MemReadData,
    output ReqReady, RspValid, RspRData, AlignErr, MemAddress, MemWriteData, MemWrite, MemRead
  );

endinterface

// File: rtl/mem_access_ctrl_lane_align.sv
// mem_lane_align: purely combinational lane handling for one 32-bit word.
// Extracts (and optionally sign-extends) the addressed byte/half for loads
// and builds the read-modify-write word for sub-word stores.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        isSigned,
  input  logic [31:0] storeData,
  output logic [31:0] loadValue,
  output logic [31:0] mergedWord
);

  logic [4:0]  byteShift_s;
  logic [4:0]  halfShift_s;
  logic [7:0]  byteLane_s;
  logic [15:0] halfLane_s;

  // Select the addressed lane and splice store data into the word.
  always_comb begin
    byteShift_s = {addrLo, 3'b000};
    halfShift_s = {addrLo[1], 4'b0000};
    byteLane_s  = 8'(word >> byteShift_s);
    halfLane_s  = 16'(word >> halfShift_s);
    loadValue   = word;
    mergedWord  = storeData;
    case (size)
      SIZE_BYTE: begin
        loadValue  = {{24{isSigned & byteLane_s[BYTE_W-1]}}, byteLane_s};
        mergedWord = (word & ~(BYTE_MASK << byteShift_s))
                   | ({24'h00_0000, storeData[7:0]} << byteShift_s);
      end
      SIZE_HALF: begin
        loadValue  = {{16{isSigned & halfLane_s[HALF_W-1]}}, halfLane_s};
        mergedWord = (word & ~(HALF_MASK << halfShift_s))
                   | ({16'h0000, storeData[15:0]} << halfShift_s);
      end
      default: begin
        loadValue  = word;
        mergedWord = storeData;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-addressed load/store front end for the word-addressed
// DataMemory. Loads read one word and return the extracted lane; word stores
// write directly; byte/half stores do a read-modify-write. Misaligned
// requests complete in one cycle with AlignErr and never touch memory.
// Optional: define MEM_ACCESS_CNT_EN to add LoadCount/StoreCount outputs.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic        Clk,
  input  logic        Reset,
`ifdef MEM_ACCESS_CNT_EN
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount,
`endif
  mem_access_ctrl_if.slave bus
);

  state_t      state_r;
  logic [1:0]  reqSize_r;
  logic        reqSigned_r;
  logic [1:0]  reqLane_r;
  logic [31:0] reqWData_r;

  logic        acceptMis_s;
  logic [31:0] loadValue_s;
  logic [31:0] mergedWord_s;
  logic        unusedAddrBits_s;

  // Bytes above the word index do not select anything; the index wraps.
  assign unusedAddrBits_s = &{1'b0, bus.ReqAddr[31:ADDR_W+2]};
  assign acceptMis_s      = isMisaligned(bus.ReqSize, bus.ReqAddr[1:0]);

  // Lane logic always looks at the live memory word and the latched request.
  mem_lane_align uLaneAlign (
    .word       (bus.MemReadData),
    .addrLo     (reqLane_r),
    .size       (reqSize_r),
    .isSigned   (reqSigned_r),
    .storeData  (reqWData_r),
    .loadValue  (loadValue_s),
    .mergedWord (mergedWord_s)
  );

  // Main FSM: request latch, memory strobes and response, all registered.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r          <= ST_IDLE;
      reqSize_r        <= 2'b00;
      reqSigned_r      <= 1'b0;
      reqLane_r        <= 2'b00;
      reqWData_r       <= 32'h0000_0000;
      bus.ReqReady     <= 1'b1;
      bus.RspValid     <= 1'b0;
      bus.RspRData     <= 32'h0000_0000;
      bus.AlignErr     <= 1'b0;
      bus.MemAddress   <= 32'h0000_0000;
      bus.MemWriteData <= 32'h0000_0000;
      bus.MemWrite     <= 1'b0;
      bus.MemRead      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.ReqValid) begin
            reqSize_r      <= bus.ReqSize;
            reqSigned_r    <= bus.ReqSigned;
            reqLane_r      <= bus.ReqAddr[1:0];
            reqWData_r     <= bus.ReqWData;
            bus.ReqReady   <= 1'b0;
            bus.MemAddress <= 32'(bus.ReqAddr[ADDR_W+1:2]);
            if (acceptMis_s) begin
              state_r      <= ST_DONE;
              bus.RspValid <= 1'b1;
              bus.AlignErr <= 1'b1;
              bus.RspRData <= 32'h0000_0000;
            end else if (!bus.ReqWrite) begin
              state_r     <= ST_LOAD;
              bus.MemRead <= 1'b1;
            end else if (bus.ReqSize[1]) begin
              state_r          <= ST_STORE;
              bus.MemWrite     <= 1'b1;
              bus.MemWriteData <= bus.ReqWData;
            end else begin
              state_r     <= ST_RMW_RD;
              bus.MemRead <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          bus.MemRead  <= 1'b0;
          bus.RspRData <= loadValue_s;
          bus.RspValid <= 1'b1;
          state_r      <= ST_DONE;
        end
        ST_STORE: begin
          bus.MemWrite     <= 1'b0;
          bus.MemWriteData <= 32'h0000_0000;
          bus.RspValid     <= 1'b1;
          state_r          <= ST_DONE;
        end
        ST_RMW_RD: begin
          // MemWriteData doubles as the merge register for the write phase.
          bus.MemRead      <= 1'b0;
          bus.MemWrite     <= 1'b1;
          bus.MemWriteData <= mergedWord_s;
          state_r          <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          bus.MemWrite     <= 1'b0;
          bus.MemWriteData <= 32'h0000_0000;
          bus.RspValid     <= 1'b1;
          state_r          <= ST_DONE;
        end
        ST_DONE: begin
          bus.RspValid   <= 1'b0;
          bus.AlignErr   <= 1'b0;
          bus.ReqReady   <= 1'b1;
          bus.MemAddress <= 32'h0000_0000;
          state_r        <= ST_IDLE;
        end
        default: begin
          state_r          <= ST_IDLE;
          bus.ReqReady     <= 1'b1;
          bus.RspValid     <= 1'b0;
          bus.AlignErr     <= 1'b0;
          bus.MemAddress   <= 32'h0000_0000;
          bus.MemWriteData <= 32'h0000_0000;
          bus.MemWrite     <= 1'b0;
          bus.MemRead      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  logic reqWrite_r;
  logic reqMis_r;

  // Remember the request kind and alignment for the completion counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      reqWrite_r <= 1'b0;
      reqMis_r   <= 1'b0;
    end else if (state_r == ST_IDLE && bus.ReqValid) begin
      reqWrite_r <= bus.ReqWrite;
      reqMis_r   <= acceptMis_s;
    end
  end

  // Count successful loads and stores as they complete; wrap naturally.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      LoadCount  <= 32'h0000_0000;
      StoreCount <= 32'h0000_0000;
    end else if (state_r == ST_DONE && !reqMis_r) begin
      if (reqWrite_r) begin
        StoreCount <= StoreCount + 32'h0000_0001;
      end else begin
        LoadCount <= LoadCount + 32'h0000_0001;
      end
    end
  end
`endif

endmodule
